// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused across WIDTH cycles; valid/ready on both sides.
module serial_borrow_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH:0]   res_shift;

  always_comb begin
    d_bit     = a_q[0] ^ b_q[0] ^ br_q;
    br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit  = (cnt_q == CW'(WIDTH - 1));
    res_shift = {d_bit, res_q};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        res_d = res_shift[WIDTH:1];
        cnt_d = cnt_q + CW'(1);
        // Visible result is committed only once all bits are in, never partially.
        if (last_bit) begin
          diff_d  = res_shift[WIDTH:1];
          bout_d  = br_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held low during reset so nothing is offered as accepted while rst is asserted.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor at WIDTH 8, 16 and 1: stimulus pushes
// expected {bout,diff} and accept cycle; per-instance monitors pop on out_valid rising.
module tb_serial_borrow_subtractor;

  typedef struct {
    logic [64:0] exp;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   rand_or = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH = 8
  logic       iv8 = 0, ir8, ov8, or8 = 1, bin8 = 0, bo8;
  logic [7:0] a8 = 0, b8 = 0, d8;
  // WIDTH = 16
  logic        iv16 = 0, ir16, ov16, or16 = 1, bin16 = 0, bo16;
  logic [15:0] a16 = 0, b16 = 0, d16;
  // WIDTH = 1
  logic       iv1 = 0, ir1, ov1, or1 = 1, bin1 = 0, bo1;
  logic [0:0] a1 = 0, b1 = 0, d1;

  serial_borrow_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8));
  serial_borrow_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16));
  serial_borrow_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .bin(bin1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1));

  exp_t q8[$];
  exp_t q16[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- monitors ----------------
  logic        pv8 = 0, pv16 = 0, pv1 = 0;
  logic [64:0] h8, h16, h1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) pv8 = 1'b0;
    else begin
      if (ov8 && !pv8) begin
        if (q8.size() == 0) timeout("unexpected_result8");
        else begin
          e = q8.pop_front();
          check("result8", 65'({bo8, d8}), e.exp);
          check("latency8", 65'(cyc - e.acc), 65'd8);
        end
        h8 = 65'({bo8, d8});
      end else if (ov8) check("hold8", 65'({bo8, d8}), h8);
      pv8 = ov8;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) pv16 = 1'b0;
    else begin
      if (ov16 && !pv16) begin
        if (q16.size() == 0) timeout("unexpected_result16");
        else begin
          e = q16.pop_front();
          check("result16", 65'({bo16, d16}), e.exp);
          check("latency16", 65'(cyc - e.acc), 65'd16);
        end
        h16 = 65'({bo16, d16});
      end else if (ov16) check("hold16", 65'({bo16, d16}), h16);
      pv16 = ov16;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) pv1 = 1'b0;
    else begin
      if (ov1 && !pv1) begin
        if (q1.size() == 0) timeout("unexpected_result1");
        else begin
          e = q1.pop_front();
          check("result1", 65'({bo1, d1}), e.exp);
          check("latency1", 65'(cyc - e.acc), 65'd1);
        end
        h1 = 65'({bo1, d1});
      end else if (ov1) check("hold1", 65'({bo1, d1}), h1);
      pv1 = ov1;
    end
  end

  always @(negedge clk) if (rand_or) or8 = 1'($urandom_range(0, 1));

  // ---------------- drivers ----------------
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [8:0] exp);
    int n = 0;
    while (!ir8 && n < 200) begin @(negedge clk); n++; end
    if (!ir8) begin timeout("ready8"); return; end
    iv8 = 1; a8 = a; b8 = b; bin8 = bin;
    q8.push_back('{exp: 65'(exp), acc: cyc + 1});
    @(negedge clk);
    // Scramble inputs during RUN; they must not affect the result.
    iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [16:0] exp);
    int n = 0;
    while (!ir16 && n < 200) begin @(negedge clk); n++; end
    if (!ir16) begin timeout("ready16"); return; end
    iv16 = 1; a16 = a; b16 = b; bin16 = bin;
    q16.push_back('{exp: 65'(exp), acc: cyc + 1});
    @(negedge clk);
    iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic send1(input logic a, input logic b, input logic bin, input logic [1:0] exp);
    int n = 0;
    while (!ir1 && n < 200) begin @(negedge clk); n++; end
    if (!ir1) begin timeout("ready1"); return; end
    iv1 = 1; a1 = a; b1 = b; bin1 = bin;
    q1.push_back('{exp: 65'(exp), acc: cyc + 1});
    @(negedge clk);
    iv1 = 0; a1 = 1'($urandom); b1 = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q16.size() != 0 || q1.size() != 0) timeout("drain");
    repeat (2) @(negedge clk);
  endtask

  // {bout,diff} for WIDTH=1 indexed by {a,b,bin}, worked out by hand.
  logic [1:0] tt1 [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

  initial begin
    logic [7:0] ra, rb;
    logic       rbin;
    logic [2:0] idx;
    int         n;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 65'(ir8), 65'd0);
    check("rst_out_valid", 65'(ov8), 65'd0);
    check("rst_diff", 65'(d8), 65'd0);
    check("rst_bout", 65'(bo8), 65'd0);
    rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", 65'(ir8), 65'd1);

    send8(8'h22, 8'h11, 1'b0, {1'b0, 8'h11});
    send8(8'hAA, 8'hCC, 1'b0, {1'b1, 8'hDE});
    send8(8'h00, 8'h01, 1'b0, {1'b1, 8'hFF});
    send8(8'h00, 8'h00, 1'b1, {1'b1, 8'hFF});
    send8(8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF});
    drain();

    // Backpressure: hold out_ready low, pulse in_valid while DONE.
    or8 = 0;
    send8(8'h3C, 8'h0F, 1'b0, {1'b0, 8'h2D});
    n = 0;
    while (!ov8 && n < 50) begin @(negedge clk); n++; end
    if (!ov8) timeout("bp_wait");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 65'(ov8), 65'd1);
      check("bp_diff", 65'(d8), 65'h2D);
      check("bp_in_ready", 65'(ir8), 65'd0);
      iv8 = 1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
    end
    check("bp_out_valid_end", 65'(ov8), 65'd1);
    check("bp_in_ready_end", 65'(ir8), 65'd0);
    iv8 = 0; or8 = 1;
    @(negedge clk);
    check("bp_release_valid", 65'(ov8), 65'd0);
    check("bp_release_ready", 65'(ir8), 65'd1);
    check("bp_diff_kept", 65'(d8), 65'h2D);
    repeat (2) @(negedge clk);

    // Reset after 3 bits of an op; no result may come out.
    iv8 = 1; a8 = 8'h77; b8 = 8'h11; bin8 = 0;
    @(negedge clk);
    iv8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_out_valid", 65'(ov8), 65'd0);
    check("midrst_diff", 65'(d8), 65'd0);
    check("midrst_bout", 65'(bo8), 65'd0);
    rst = 0;
    @(negedge clk);
    check("midrst_in_ready", 65'(ir8), 65'd1);
    send8(8'h05, 8'h03, 1'b0, {1'b0, 8'h02});
    drain();

    send16(16'h1234, 16'h5678, 1'b0, {1'b1, 16'hBBBC});
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      send1(idx[2], idx[1], idx[0], tt1[i]);
    end
    drain();

    rand_or = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      send8(ra, rb, rbin, {1'b0, ra} - {1'b0, rb} - {8'd0, rbin});
    end
    rand_or = 0;
    or8 = 1;
    drain();
    check("final_q8_empty", 65'(q8.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
